// File: rtl/spi_packet_master_if.sv
// rtl/spi_packet_master_if.sv - frame request and serial line signals of the SPI packet master
interface spi_packet_master_if #(
  parameter int size = 8
);
  logic            start;
  logic            desPort;
  logic [size-1:0] dataIn;
  logic            forceError;
  logic            masterClock;
  logic            bitOut;
  logic            busy;
  logic            done;

  modport master (
    input  start, desPort, dataIn, forceError,
    output masterClock, bitOut, busy, done
  );

  modport slave (
    output start, desPort, dataIn, forceError,
    input  masterClock, bitOut, busy, done
  );
endinterface

// File: rtl/spi_packet_master.sv
// rtl/spi_packet_master.sv - serialises desPort, payload (MSB first) and parity onto masterClock/bitOut
module spi_packet_master #(
  parameter int size       = 8,
  parameter int halfPeriod = 4
) (
  input logic                 clock,
  input logic                 reset,
  spi_packet_master_if.master bus
);
  localparam int PW = (2 * halfPeriod > 1) ? $clog2(2 * halfPeriod) : 1;
  localparam int BW = $clog2(size + 2);
  localparam logic [PW-1:0] PH_RISE  = PW'(halfPeriod - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * halfPeriod - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(size + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_phase;
  logic [BW-1:0]   r_bit;
  logic [size:0]   r_shift;
  logic            r_mclk;
  logic            r_bit_out;
  logic            r_busy;
  logic            r_done;
  logic            w_parity;

  // Even parity over desPort and payload; forceError flips it for error injection.
  assign w_parity = (^{bus.desPort, bus.dataIn}) ^ bus.forceError;

  assign bus.masterClock = r_mclk;
  assign bus.bitOut      = r_bit_out;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_mclk    <= 1'b0;
      r_bit_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state   <= SEND;
            r_shift   <= {bus.dataIn, w_parity};
            r_bit_out <= bus.desPort;
            r_busy    <= 1'b1;
            r_mclk    <= 1'b0;
            r_phase   <= '0;
            r_bit     <= '0;
          end
        end
        SEND: begin
          if (r_phase == PH_LAST) begin
            // Bit boundary: masterClock returns low and the next bit is launched together.
            r_phase <= '0;
            r_mclk  <= 1'b0;
            if (r_bit == BIT_LAST) begin
              r_state   <= DONE;
              r_bit     <= '0;
              r_shift   <= '0;
              r_bit_out <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit     <= r_bit + 1'b1;
              r_bit_out <= r_shift[size];
              r_shift   <= {r_shift[size-1:0], 1'b0};
            end
          end else begin
            r_phase <= r_phase + 1'b1;
            if (r_phase == PH_RISE) begin
              r_mclk <= 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_packet_master.sv
// tb/tb_spi_packet_master.sv - scoreboard bench: stimulus queues expected frames, monitor checks the wire
module tb_spi_packet_master;
  logic clock;
  logic reset;

  spi_packet_master_if #(.size(8)) if4 ();
  spi_packet_master_if #(.size(8)) if1 ();

  spi_packet_master #(.size(8), .halfPeriod(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (if4)
  );

  spi_packet_master #(.size(8), .halfPeriod(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected entries: {receiver parity error, 10 frame bits in wire order}.
  localparam logic [10:0] E_A5_D1     = {1'b0, 10'b1101001011};
  localparam logic [10:0] E_00_D0_FE1 = {1'b1, 10'b0000000001};
  localparam logic [10:0] E_00_D0     = {1'b0, 10'b0000000000};
  localparam logic [10:0] E_3C_D0     = {1'b0, 10'b0001111000};
  localparam logic [10:0] E_C8_D1     = {1'b0, 10'b1110010000};
  localparam logic [10:0] E_C8_D1_FE1 = {1'b1, 10'b1110010001};

  logic [10:0] q0[$];
  logic [10:0] q1[$];

  logic       prev_mc[2];
  logic       prev_busy[2];
  logic       prev_done[2];
  logic       hi_bo[2];
  int         hi_run[2];
  int         lo_run[2];
  int         nb[2];
  int         bcnt[2];
  logic [9:0] rx[2];
  logic       rx_err[2];
  logic [7:0] port2[2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic mon_step(input int d, input logic mc, input logic bo, input logic bz, input logic dn);
    int          hp;
    logic [10:0] e;
    hp = (d == 0) ? 4 : 1;
    if (reset) begin
      prev_mc[d] = 1'b0; prev_busy[d] = 1'b0; prev_done[d] = 1'b0;
      hi_run[d] = 0; lo_run[d] = 0; nb[d] = 0; bcnt[d] = 0; rx[d] = '0;
      return;
    end
    if (mc && !prev_mc[d]) begin
      if (bz) chk($sformatf("mclk_low_len%0d", d), lo_run[d], hp);
      lo_run[d] = 0;
      rx[d] = {rx[d][8:0], bo};
      nb[d]++;
      hi_bo[d] = bo;
      hi_run[d] = 1;
    end else if (mc) begin
      hi_run[d]++;
      chk($sformatf("bit_stable_high%0d", d), int'(bo), int'(hi_bo[d]));
    end else begin
      if (prev_mc[d]) chk($sformatf("mclk_high_len%0d", d), hi_run[d], hp);
      if (bz) lo_run[d]++;
    end
    if (bz) begin
      bcnt[d]++;
    end else begin
      if (prev_busy[d] && dn) chk($sformatf("busy_len%0d", d), bcnt[d], 20 * hp);
      bcnt[d] = 0;
    end
    if (dn) begin
      chk($sformatf("done_width%0d", d), int'(prev_done[d]), 0);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done%0d: got done pulse expected none", d);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("frame_bits%0d", d), int'(rx[d]), int'(e[9:0]));
        chk($sformatf("frame_len%0d", d), nb[d], 10);
        rx_err[d] = ^rx[d];
        chk($sformatf("rx_parity_err%0d", d), int'(rx_err[d]), int'(e[10]));
        if (!rx_err[d] && rx[d][9]) port2[d] = rx[d][8:1];
      end
      nb[d] = 0;
    end
    prev_mc[d]   = mc;
    prev_busy[d] = bz;
    prev_done[d] = dn;
  endtask

  always @(negedge clock) begin
    mon_step(0, if4.masterClock, if4.bitOut, if4.busy, if4.done);
    mon_step(1, if1.masterClock, if1.bitOut, if1.busy, if1.done);
  end

  task automatic launch4(input logic dp, input logic [7:0] data, input logic fe,
                         input logic [10:0] e, input bit push);
    @(posedge clock); #1;
    if4.desPort = dp; if4.dataIn = data; if4.forceError = fe; if4.start = 1'b1;
    if (push) q0.push_back(e);
    @(posedge clock); #1;
    if4.start = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!((d == 0) ? if4.done : if1.done) && n < 400);
    if (!((d == 0) ? if4.done : if1.done)) begin
      checks++;
      errors++;
      $display("FAIL done_timeout%0d: got no done within %0d cycles expected a done pulse", d, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bzc;
    int gap;
    reset = 1'b1;
    if4.start = 1'b0; if4.desPort = 1'b0; if4.dataIn = '0; if4.forceError = 1'b0;
    if1.start = 1'b0; if1.desPort = 1'b0; if1.dataIn = '0; if1.forceError = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mclk4", int'(if4.masterClock), 0);
    chk("rst_bitout4", int'(if4.bitOut), 0);
    chk("rst_busy4", int'(if4.busy), 0);
    chk("rst_done4", int'(if4.done), 0);
    chk("rst_mclk1", int'(if1.masterClock), 0);
    chk("rst_busy1", int'(if1.busy), 0);
    reset = 1'b0;

    launch4(1'b1, 8'hA5, 1'b0, E_A5_D1, 1'b1);
    wait_done(0);
    launch4(1'b0, 8'h00, 1'b1, E_00_D0_FE1, 1'b1);
    wait_done(0);
    launch4(1'b0, 8'h00, 1'b0, E_00_D0, 1'b1);
    wait_done(0);

    // Re-request with different data mid-frame must not disturb the 3C frame.
    launch4(1'b0, 8'h3C, 1'b0, E_3C_D0, 1'b1);
    repeat (19) @(posedge clock);
    #1;
    if4.start = 1'b1; if4.dataIn = 8'hFF; if4.desPort = 1'b1; if4.forceError = 1'b1;
    @(posedge clock); #1;
    if4.start = 1'b0;
    wait_done(0);
    bzc = 0;
    repeat (30) begin
      @(negedge clock);
      if (if4.busy) bzc++;
    end
    chk("no_second_frame", bzc, 0);

    // Abandon a frame with reset around cycle 30.
    launch4(1'b1, 8'hC8, 1'b0, E_C8_D1, 1'b0);
    repeat (29) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_mclk", int'(if4.masterClock), 0);
    chk("abort_bitout", int'(if4.bitOut), 0);
    chk("abort_busy", int'(if4.busy), 0);
    chk("abort_done", int'(if4.done), 0);
    reset = 1'b0;
    bzc = 0;
    repeat (100) begin
      @(negedge clock);
      if (if4.done || if4.busy) bzc++;
    end
    chk("abort_quiet", bzc, 0);

    launch4(1'b1, 8'hC8, 1'b0, E_C8_D1, 1'b1);
    wait_done(0);
    @(posedge clock); #1;
    chk("loop_port2", int'(port2[0]), 200);
    chk("loop_no_err", int'(rx_err[0]), 0);
    launch4(1'b1, 8'hC8, 1'b1, E_C8_D1_FE1, 1'b1);
    wait_done(0);
    @(posedge clock); #1;
    chk("loop_err", int'(rx_err[0]), 1);

    // Reset wins over start on the same edge.
    @(posedge clock); #1;
    reset = 1'b1; if4.start = 1'b1;
    @(posedge clock); #1;
    chk("prio_busy", int'(if4.busy), 0);
    chk("prio_bitout", int'(if4.bitOut), 0);
    reset = 1'b0; if4.start = 1'b0;

    // halfPeriod=1 with start held: back-to-back frames.
    if1.desPort = 1'b1; if1.dataIn = 8'hA5; if1.forceError = 1'b0;
    q1.push_back(E_A5_D1); q1.push_back(E_A5_D1); q1.push_back(E_A5_D1);
    @(posedge clock); #1;
    if1.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(1);
      if (k < 2) begin
        gap = 1;
        while (!if1.busy && gap < 20) begin
          @(negedge clock);
          if (!if1.busy) gap++;
        end
        chk($sformatf("b2b_gap%0d", k), gap, 2);
      end else begin
        @(posedge clock); #1;
        if1.start = 1'b0;
      end
    end
    bzc = 0;
    repeat (10) begin
      @(negedge clock);
      if (if1.busy) bzc++;
    end
    chk("hp1_stopped", bzc, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
